// File: rtl/conn_table_arbiter.sv
// conn_table_arbiter
//   Shares the single-port connection-config table RAM between NUM_REQ
//   ingress lookup requesters and one AXI-lite config read/write path.
//   After reset the whole table is scrubbed to zero, then one RAM access is
//   granted per cycle through a 3-cycle pipeline (grant -> RAM strobe ->
//   RAM data -> registered response).
//
//   Optional feature macro: LOOKUP_STATS_EN
//     defined   : stat_hit_cnt / stat_miss_cnt count lookup hits/misses
//     undefined : both ports tied to 0
//
// Ports
//   reg_clk, reset_n            clock, synchronous active-low reset
//   init_done                   high once the scrub has finished
//   lk_req_valid/index/ready    per-requester lookup request, one-hot grant
//   lk_rsp_valid/data/hit       one-hot response strobe, shared data, bit 7
//   cfg_valid/we/index/wdata    config request
//   cfg_ready                   config grant
//   cfg_rsp_valid/rdata         config response (rdata 0 for writes)
//   mem_en/we/addr/wdata        RAM strobe, registered
//   mem_rdata                   RAM data, valid the cycle after mem_en
//   stat_hit_cnt/stat_miss_cnt  lookup statistics
module conn_table_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int DATA_SIZE    = 32,
  parameter int INDEX_SIZE   = 15,
  parameter int CFG_MAX_HOLD = 8
) (
  input  logic                          reg_clk,
  input  logic                          reset_n,
  output logic                          init_done,
  input  logic [NUM_REQ-1:0]            lk_req_valid,
  input  logic [NUM_REQ*INDEX_SIZE-1:0] lk_req_index,
  output logic [NUM_REQ-1:0]            lk_req_ready,
  output logic [NUM_REQ-1:0]            lk_rsp_valid,
  output logic [DATA_SIZE-1:0]          lk_rsp_data,
  output logic                          lk_rsp_hit,
  input  logic                          cfg_valid,
  input  logic                          cfg_we,
  input  logic [INDEX_SIZE-1:0]         cfg_index,
  input  logic [DATA_SIZE-1:0]          cfg_wdata,
  output logic                          cfg_ready,
  output logic                          cfg_rsp_valid,
  output logic [DATA_SIZE-1:0]          cfg_rdata,
  output logic                          mem_en,
  output logic                          mem_we,
  output logic [INDEX_SIZE-1:0]         mem_addr,
  output logic [DATA_SIZE-1:0]          mem_wdata,
  input  logic [DATA_SIZE-1:0]          mem_rdata,
  output logic [31:0]                   stat_hit_cnt,
  output logic [31:0]                   stat_miss_cnt
);

  localparam int ID_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int HOLD_W = $clog2(CFG_MAX_HOLD + 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(CFG_MAX_HOLD);

  typedef enum logic {S_INIT, S_RUN} state_t;

  // tag carried alongside an access until its response is produced
  typedef struct packed {
    logic            is_cfg;
    logic            we;
    logic [ID_W-1:0] id;
  } tag_t;

  state_t                  state, state_nx;
  logic [INDEX_SIZE-1:0]   scrub_cnt;
  logic [ID_W-1:0]         rr_ptr, rr_ptr_nx;
  logic [HOLD_W-1:0]       streak, streak_nx;
  logic                    any_lk;
  logic                    lk_gnt;
  logic [ID_W-1:0]         lk_gnt_id;
  logic [INDEX_SIZE-1:0]   lk_gnt_index;
  logic [1:0]              vld_pipe;
  tag_t [1:0]              tag_pipe;

  assign any_lk = |lk_req_valid;

  // Next state + arbitration. Grants wait for init_done so nothing is
  // granted until the scrub write of the last index has been issued.
  always_comb begin : arb
    int c;
    state_nx     = state;
    rr_ptr_nx    = rr_ptr;
    streak_nx    = streak;
    lk_req_ready = '0;
    cfg_ready    = 1'b0;
    lk_gnt       = 1'b0;
    lk_gnt_id    = '0;
    lk_gnt_index = '0;
    c            = 0;
    case (state)
      S_INIT: if (&scrub_cnt) state_nx = S_RUN;
      S_RUN: if (init_done) begin
        if (cfg_valid && (streak < HOLD_MAX || !any_lk)) begin
          cfg_ready = 1'b1;
          // streak only counts config wins over pending lookups
          if (!any_lk)               streak_nx = '0;
          else if (streak < HOLD_MAX) streak_nx = streak + 1'b1;
        end else if (any_lk) begin
          for (int k = 0; k < NUM_REQ; k++) begin
            c = (int'(rr_ptr) + k) % NUM_REQ;
            if (!lk_gnt && lk_req_valid[c]) begin
              lk_gnt          = 1'b1;
              lk_gnt_id       = ID_W'(c);
              lk_gnt_index    = lk_req_index[c*INDEX_SIZE +: INDEX_SIZE];
              lk_req_ready[c] = 1'b1;
              rr_ptr_nx       = ID_W'((c + 1) % NUM_REQ);
            end
          end
          streak_nx = '0;
        end
      end
      default: state_nx = S_INIT;
    endcase
  end

  always_ff @(posedge reg_clk) begin
    if (!reset_n) begin
      state         <= S_INIT;
      scrub_cnt     <= '0;
      rr_ptr        <= '0;
      streak        <= '0;
      init_done     <= 1'b0;
      mem_en        <= 1'b0;
      mem_we        <= 1'b0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
      vld_pipe      <= '0;
      tag_pipe      <= '0;
      lk_rsp_valid  <= '0;
      lk_rsp_data   <= '0;
      lk_rsp_hit    <= 1'b0;
      cfg_rsp_valid <= 1'b0;
      cfg_rdata     <= '0;
    end else begin
      state     <= state_nx;
      rr_ptr    <= rr_ptr_nx;
      streak    <= streak_nx;
      init_done <= (state == S_RUN);

      // stage 1: RAM strobe
      mem_wdata <= '0;
      if (state == S_INIT) begin
        scrub_cnt <= scrub_cnt + 1'b1;
        mem_en    <= 1'b1;
        mem_we    <= 1'b1;
        mem_addr  <= scrub_cnt;
      end else if (cfg_ready) begin
        mem_en    <= 1'b1;
        mem_we    <= cfg_we;
        mem_addr  <= cfg_index;
        mem_wdata <= cfg_we ? cfg_wdata : '0;
      end else if (lk_gnt) begin
        mem_en    <= 1'b1;
        mem_we    <= 1'b0;
        mem_addr  <= lk_gnt_index;
      end else begin
        mem_en    <= 1'b0;
        mem_we    <= 1'b0;
      end
      vld_pipe[0] <= cfg_ready | lk_gnt;
      tag_pipe[0] <= '{is_cfg: cfg_ready, we: cfg_ready & cfg_we, id: lk_gnt_id};

      // stage 2: RAM data arrives
      vld_pipe[1] <= vld_pipe[0];
      tag_pipe[1] <= tag_pipe[0];

      // stage 3: registered response
      lk_rsp_valid  <= '0;
      cfg_rsp_valid <= 1'b0;
      if (vld_pipe[1]) begin
        if (tag_pipe[1].is_cfg) begin
          cfg_rsp_valid <= 1'b1;
          cfg_rdata     <= tag_pipe[1].we ? '0 : mem_rdata;
        end else begin
          lk_rsp_valid[tag_pipe[1].id] <= 1'b1;
          lk_rsp_data                  <= mem_rdata;
          lk_rsp_hit                   <= mem_rdata[7];
        end
      end
    end
  end

`ifdef LOOKUP_STATS_EN
  always_ff @(posedge reg_clk) begin
    if (!reset_n || !init_done) begin
      stat_hit_cnt  <= '0;
      stat_miss_cnt <= '0;
    end else if (|lk_rsp_valid) begin
      if (lk_rsp_hit) begin
        if (~&stat_hit_cnt) stat_hit_cnt <= stat_hit_cnt + 1'b1;
      end else begin
        if (~&stat_miss_cnt) stat_miss_cnt <= stat_miss_cnt + 1'b1;
      end
    end
  end
`else
  assign stat_hit_cnt  = '0;
  assign stat_miss_cnt = '0;
`endif

endmodule

// File: tb/tb_conn_table_arbiter.sv
// Bench for conn_table_arbiter with a 16-entry table. A behavioural RAM
// sits on the mem_* port; expected responses go into a scoreboard queue
// when a grant is seen and are compared (data and 3-cycle latency) when
// the DUT responds.
module tb_conn_table_arbiter;
  localparam int NR = 4;
  localparam int DW = 32;
  localparam int IW = 4;

  logic            reg_clk = 1'b0;
  logic            reset_n;
  logic            init_done;
  logic [NR-1:0]   lk_req_valid;
  logic [NR*IW-1:0] lk_req_index;
  logic [NR-1:0]   lk_req_ready;
  logic [NR-1:0]   lk_rsp_valid;
  logic [DW-1:0]   lk_rsp_data;
  logic            lk_rsp_hit;
  logic            cfg_valid, cfg_we;
  logic [IW-1:0]   cfg_index;
  logic [DW-1:0]   cfg_wdata;
  logic            cfg_ready, cfg_rsp_valid;
  logic [DW-1:0]   cfg_rdata;
  logic            mem_en, mem_we;
  logic [IW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wdata, mem_rdata;
  logic [31:0]     stat_hit_cnt, stat_miss_cnt;

  conn_table_arbiter #(.NUM_REQ(NR), .DATA_SIZE(DW), .INDEX_SIZE(IW), .CFG_MAX_HOLD(8)) dut (
    .reg_clk(reg_clk), .reset_n(reset_n), .init_done(init_done),
    .lk_req_valid(lk_req_valid), .lk_req_index(lk_req_index), .lk_req_ready(lk_req_ready),
    .lk_rsp_valid(lk_rsp_valid), .lk_rsp_data(lk_rsp_data), .lk_rsp_hit(lk_rsp_hit),
    .cfg_valid(cfg_valid), .cfg_we(cfg_we), .cfg_index(cfg_index), .cfg_wdata(cfg_wdata),
    .cfg_ready(cfg_ready), .cfg_rsp_valid(cfg_rsp_valid), .cfg_rdata(cfg_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .stat_hit_cnt(stat_hit_cnt), .stat_miss_cnt(stat_miss_cnt));

  always #5 reg_clk = ~reg_clk;

  // behavioural single-port RAM
  logic [DW-1:0] ram [0:15];
  always @(posedge reg_clk)
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata     <= ram[mem_addr];
    end

  int cyc = 0;
  always @(posedge reg_clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  int exp_hits = 0;
  int exp_miss = 0;

  typedef struct {
    logic          is_cfg;
    int            id;
    logic [DW-1:0] data;
    int            cyc;
  } exp_t;
  exp_t sbq[$];

  typedef struct {
    logic          is_cfg;
    logic          we;
    int            req;
    logic [IW-1:0] idx;
    logic [DW-1:0] wdata;
    logic [DW-1:0] exp;
  } vec_t;
  vec_t vt [10];

  task automatic chk(input string nm, input logic ok, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cyc %0d)", nm, act, req, cyc);
    end
  endtask

  task automatic push(input logic is_cfg, input int id, input logic [DW-1:0] d);
    exp_t e;
    e.is_cfg = is_cfg; e.id = id; e.data = d; e.cyc = cyc + 3;
    sbq.push_back(e);
    if (!is_cfg) begin
      if (d[7]) exp_hits++;
      else      exp_miss++;
    end
  endtask

  task automatic step();
    @(posedge reg_clk);
    #1;
  endtask

  // response monitor
  always @(negedge reg_clk) begin
    exp_t e;
    logic [NR-1:0] eh;
    if (|lk_rsp_valid || cfg_rsp_valid) begin
      if (sbq.size() == 0) begin
        chk("unexpected_rsp", 1'b0, {lk_rsp_valid, 3'b0, cfg_rsp_valid}, 0);
      end else begin
        e = sbq.pop_front();
        eh = NR'(1 << e.id);
        chk("rsp_latency", cyc == e.cyc, cyc, e.cyc);
        if (e.is_cfg)
          chk("cfg_rsp", cfg_rsp_valid && lk_rsp_valid == 0 && cfg_rdata == e.data,
              {cfg_rsp_valid, lk_rsp_valid, cfg_rdata}, {1'b1, 4'b0, e.data});
        else
          chk("lk_rsp", !cfg_rsp_valid && lk_rsp_valid == eh && lk_rsp_data == e.data && lk_rsp_hit == e.data[7],
              {lk_rsp_valid, lk_rsp_hit, lk_rsp_data}, {eh, e.data[7], e.data});
      end
    end
  end

  task automatic issue(input vec_t v);
    int  n;
    bit  got;
    n = 0; got = 0;
    if (v.is_cfg) begin
      cfg_valid = 1'b1; cfg_we = v.we; cfg_index = v.idx; cfg_wdata = v.wdata;
    end else begin
      lk_req_valid[v.req] = 1'b1;
      lk_req_index[v.req*IW +: IW] = v.idx;
    end
    while (!got && n < 30) begin
      @(negedge reg_clk);
      if (v.is_cfg ? cfg_ready : lk_req_ready[v.req]) begin
        got = 1;
        push(v.is_cfg, v.req, v.exp);
      end
      step();
      n++;
    end
    cfg_valid = 1'b0; lk_req_valid = '0;
    chk("grant_wait", got, n, 30);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sbq.size() > 0 && n < 20) begin
      @(negedge reg_clk);
      n++;
    end
    @(negedge reg_clk);
    chk("drain", sbq.size() == 0, sbq.size(), 0);
  endtask

  task automatic stats_chk();
    int eh, em;
`ifdef LOOKUP_STATS_EN
    eh = exp_hits; em = exp_miss;
`else
    eh = 0; em = 0;
`endif
    chk("stat_hit", stat_hit_cnt == 32'(eh), stat_hit_cnt, eh);
    chk("stat_miss", stat_miss_cnt == 32'(em), stat_miss_cnt, em);
  endtask

  initial begin
    int n;
    logic [NR-1:0] eg;
    logic is_c;
    int lid;

    vt[0] = '{1'b1, 1'b1, 0, 4'd0,  32'h1234_5680, 32'h0};
    vt[1] = '{1'b0, 1'b0, 0, 4'd0,  32'h0,         32'h1234_5680};
    vt[2] = '{1'b1, 1'b1, 0, 4'd15, 32'hDEAD_BE00, 32'h0};
    vt[3] = '{1'b0, 1'b0, 3, 4'd15, 32'h0,         32'hDEAD_BE00};
    vt[4] = '{1'b1, 1'b0, 0, 4'd15, 32'h0,         32'hDEAD_BE00};
    vt[5] = '{1'b0, 1'b0, 1, 4'd5,  32'h0,         32'h0000_0080};
    vt[6] = '{1'b1, 1'b0, 0, 4'd0,  32'h0,         32'h1234_5680};
    vt[7] = '{1'b1, 1'b1, 0, 4'd5,  32'h0,         32'h0};
    vt[8] = '{1'b0, 1'b0, 2, 4'd5,  32'h0,         32'h0};
    vt[9] = '{1'b0, 1'b0, 0, 4'd15, 32'h0,         32'hDEAD_BE00};

    reset_n = 1'b0;
    lk_req_valid = '0; lk_req_index = '0;
    cfg_valid = 1'b0; cfg_we = 1'b0; cfg_index = '0; cfg_wdata = '0;

    // reset state
    repeat (3) @(posedge reg_clk);
    @(negedge reg_clk);
    chk("reset_outputs",
        !init_done && lk_req_ready == 0 && lk_rsp_valid == 0 && !cfg_ready && !cfg_rsp_valid &&
        !mem_en && !mem_we && mem_addr == 0 && lk_rsp_data == 0 && cfg_rdata == 0 &&
        stat_hit_cnt == 0 && stat_miss_cnt == 0, {init_done, mem_en, mem_addr}, 0);

    // scrub with requests pending: no grants
    step();
    reset_n = 1'b1;
    lk_req_valid = '1; cfg_valid = 1'b1; cfg_we = 1'b1; cfg_index = 4'd2;
    for (int k = 1; k <= 16; k++) begin
      @(posedge reg_clk);
      @(negedge reg_clk);
      chk("scrub_write", mem_en && mem_we && mem_addr == IW'(k-1) && mem_wdata == 0,
          {mem_en, mem_we, mem_addr, mem_wdata}, {2'b11, 4'(k-1), 32'h0});
      chk("scrub_no_ready", lk_req_ready == 0 && !cfg_ready && !init_done,
          {lk_req_ready, cfg_ready, init_done}, 0);
    end
    lk_req_valid = '0; cfg_valid = 1'b0;
    @(posedge reg_clk);
    @(negedge reg_clk);
    chk("init_done_rise", init_done && !mem_en, {init_done, mem_en}, 2'b10);

    // round robin from pointer 0, all scrubbed entries miss
    step();
    lk_req_valid = '1;
    for (int r = 0; r < NR; r++) lk_req_index[r*IW +: IW] = 4'd3;
    for (int g = 0; g < 5; g++) begin
      @(negedge reg_clk);
      eg = NR'(1 << (g % NR));
      chk("rr_grant", lk_req_ready == eg && !cfg_ready, lk_req_ready, eg);
      push(1'b0, g % NR, 32'h0);
      step();
    end
    lk_req_valid = '0;

    // config hold limit vs lookups 1 and 3
    cfg_valid = 1'b1; cfg_we = 1'b0; cfg_index = 4'd7;
    lk_req_valid = 4'b1010;
    lk_req_index[1*IW +: IW] = 4'd9;
    lk_req_index[3*IW +: IW] = 4'd9;
    for (int g = 0; g < 18; g++) begin
      @(negedge reg_clk);
      is_c = !(g == 8 || g == 17);
      lid  = (g == 8) ? 1 : 3;
      eg   = is_c ? '0 : NR'(1 << lid);
      chk("hold_grant", cfg_ready == is_c && lk_req_ready == eg,
          {cfg_ready, lk_req_ready}, {is_c, eg});
      push(is_c, lid, 32'h0);
      step();
    end
    cfg_valid = 1'b0; lk_req_valid = '0;

    // cfg write then back-to-back lookup of the same index
    cfg_valid = 1'b1; cfg_we = 1'b1; cfg_index = 4'd5; cfg_wdata = 32'h0000_0080;
    lk_req_valid = 4'b0100; lk_req_index[2*IW +: IW] = 4'd5;
    @(negedge reg_clk);
    chk("raw_cfg_first", cfg_ready && lk_req_ready == 0, {cfg_ready, lk_req_ready}, 5'b10000);
    push(1'b1, 0, 32'h0);
    step();
    cfg_valid = 1'b0;
    @(negedge reg_clk);
    chk("raw_lk_next", !cfg_ready && lk_req_ready == 4'b0100, {cfg_ready, lk_req_ready}, 5'b00100);
    push(1'b0, 2, 32'h0000_0080);
    step();
    lk_req_valid = '0;

    // vector table
    for (int i = 0; i < 10; i++) issue(vt[i]);
    drain();
    stats_chk();

    // reset one cycle after a lookup grant
    lk_req_valid = 4'b0001; lk_req_index[0 +: IW] = 4'd0;
    @(negedge reg_clk);
    chk("pre_reset_grant", lk_req_ready == 4'b0001, lk_req_ready, 4'b0001);
    step();
    lk_req_valid = '0;
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    exp_hits = 0; exp_miss = 0;
    for (int j = 0; j < 4; j++) begin
      @(negedge reg_clk);
      chk("reset_drop_rsp", lk_rsp_valid == 0, lk_rsp_valid, 0);
      if (j == 0) chk("reset_init", !init_done && !mem_en, {init_done, mem_en}, 0);
      else chk("rescrub_addr", mem_en && mem_we && mem_addr == IW'(j-1),
               {mem_en, mem_we, mem_addr}, {2'b11, 4'(j-1)});
    end
    n = 0;
    while (!init_done && n < 40) begin
      @(negedge reg_clk);
      n++;
    end
    chk("reinit_done", init_done, n, 40);
    step();
    vt[0] = '{1'b0, 1'b0, 1, 4'd0, 32'h0, 32'h0};
    issue(vt[0]);
    drain();
    stats_chk();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=%0d required=finish", cyc);
    $fatal(1);
  end
endmodule
